rr_arbiter_ctrl: RTL

// - Sequential round-robin arbiter sharing one resource among N requesters.
// - Owns the one-hot rotating priority vector. Issues a registered one-hot grant.
// - Holds the grant until the owner releases it, then rotates priority past the last winner.
// - Sits in front of the shared datapath. prio_o mirrors the internal priority for debug and datapath use.
//

---
 rtl/rr_arbiter_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rr_arbiter_ctrl.sv
// rr_arbiter_ctrl: sequential round-robin arbiter for N requesters.
// Issues a registered one-hot grant. The grant is held until the owner
// pulses done or withdraws its request. Priority then rotates past the
// last winner, and arbitration runs again on the same edge.
// Optional feature: define RR_ARB_TIMEOUT_EN to force-release a grant
// held for MAX_HOLD cycles and to expose the sticky timeout_o flag.

module rr_arbiter_ctrl #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
`ifdef RR_ARB_TIMEOUT_EN
  output logic                 timeout_o,
`endif
  output logic [N-1:0]         prio_o
);

  localparam int IW = $clog2(N);
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  prio, prio_nxt;
  logic [N-1:0]  gnt_nxt;
  logic [IW-1:0] id_nxt;
  logic [N-1:0]  win;
  logic          load;
  logic          release_now;
  logic          force_rel;

  // Choose the first requester at or above the priority bit, wrapping to bit 0.
  // The masked vector covers the positions from the priority bit upward. If it
  // is empty, the search wraps and takes the lowest set bit of the whole vector.
  function automatic logic [N-1:0] pick(input logic [N-1:0] r, input logic [N-1:0] p);
    logic [N-1:0] masked;
    logic [N-1:0] src;
    masked = r & ~(p - ONE);
    src    = (masked != '0) ? masked : r;
    return src & (~src + ONE);
  endfunction

  // Binary index of a one-hot vector. The result is zero for an all-zero input.
  function automatic logic [IW-1:0] to_index(input logic [N-1:0] oh);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx |= IW'(i);
    end
    return idx;
  endfunction

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] hold_cnt;
  logic          timeout_q;

  assign force_rel = (state == GRANT) && (hold_cnt == CW'(MAX_HOLD - 1));
  assign timeout_o = timeout_q;

  // Hold counter restarts on every new grant and counts the cycles the grant is held.
  // The timeout flag is set only when the forced release is what ends the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (load) begin
        hold_cnt <= '0;
      end else if (state == GRANT) begin
        hold_cnt <= hold_cnt + CW'(1);
      end
      if (force_rel && !done && req[gnt_id]) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  assign force_rel = 1'b0;
`endif

  assign release_now = done || !req[gnt_id] || force_rel;

  // Next-state logic. In IDLE, any request is granted against the current priority.
  // In GRANT, a release rotates priority past the owner and re-arbitrates at once.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    id_nxt    = gnt_id;
    prio_nxt  = prio;
    win       = '0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          win       = pick(req, prio);
          gnt_nxt   = win;
          id_nxt    = to_index(win);
          load      = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          prio_nxt = {gnt[N-2:0], gnt[N-1]};
          if (|req) begin
            win       = pick(req, prio_nxt);
            gnt_nxt   = win;
            id_nxt    = to_index(win);
            load      = 1'b1;
            state_nxt = GRANT;
          end else begin
            gnt_nxt   = '0;
            id_nxt    = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        gnt_nxt   = '0;
        id_nxt    = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, grant and priority registers. Reset discards all priority history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      prio   <= ONE;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      gnt_id <= id_nxt;
      prio   <= prio_nxt;
    end
  end

  assign busy   = |gnt;
  assign prio_o = prio;

  // Structural invariants of the grant and priority vectors.
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_prio_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot(prio));
  a_busy_state:  assert property (@(posedge clk) disable iff (!rst_n) busy == (state == GRANT));

endmodule
